gun_ay: RTL

GUN_AY -- requirements
Module: gun_ay

---
 rtl/gun_ay.sv | 134 +++++++++++++
 1 files changed

// File: rtl/gun_ay.sv
// gun_ay : day-of-month / month register pair for the calendar chain.
//
// Ports
//   clk         in   system clock, rising-edge active
//   reset       in   synchronous active-high reset
//   stop        in   1 = clock stopped (buttons active), 0 = running (gun_tick active)
//   gun_tick    in   one-cycle day-rollover pulse from the hour counter
//   yil[15:0]   in   current year, binary
//   gun_arttir  in   day increment button (level)
//   gun_azalt   in   day decrement button (level)
//   ay_arttir   in   month increment button (level)
//   ay_azalt    in   month decrement button (level)
//   gun[4:0]    out  day of month 1..31, registered
//   ay[3:0]     out  month 1..12, registered
//   yil_tasma   out  one-cycle pulse on the Dec 31 -> Jan 1 rollover
//   artik_yil   out  registered leap-year flag for yil
module gun_ay (
  input  logic        clk,
  input  logic        reset,
  input  logic        stop,
  input  logic        gun_tick,
  input  logic [15:0] yil,
  input  logic        gun_arttir,
  input  logic        gun_azalt,
  input  logic        ay_arttir,
  input  logic        ay_azalt,
  output logic [4:0]  gun,
  output logic [3:0]  ay,
  output logic        yil_tasma,
  output logic        artik_yil
);

  logic [4:0] r_gun;
  logic [3:0] r_ay;
  logic       r_tasma;
  logic       r_arm;
  logic       r_artik;

  logic [4:0] w_gun_nxt;
  logic [3:0] w_ay_nxt;
  logic       w_tasma_nxt;
  logic       w_arm_nxt;
  logic       w_act;
  logic       w_leap;
  logic       w_any_btn;
  logic [4:0] w_len;
  logic [3:0] w_ay_up;
  logic [3:0] w_ay_dn;
  logic [4:0] w_len_up;
  logic [4:0] w_len_dn;

  function automatic logic [4:0] f_month_len(input logic [3:0] m, input logic leap);
    case (m)
      4'd2:                      return leap ? 5'd29 : 5'd28;
      4'd4, 4'd6, 4'd9, 4'd11:   return 5'd30;
      default:                   return 5'd31;
    endcase
  endfunction

  assign w_leap = ((yil[1:0] == 2'b00) && ((yil % 16'd100) != 16'd0)) ||
                  ((yil % 16'd400) == 16'd0);

  assign w_any_btn = gun_arttir | gun_azalt | ay_arttir | ay_azalt;
  assign w_len     = f_month_len(r_ay, r_artik);
  assign w_ay_up   = (r_ay == 4'd12) ? 4'd1  : r_ay + 4'd1;
  assign w_ay_dn   = (r_ay == 4'd1)  ? 4'd12 : r_ay - 4'd1;
  assign w_len_up  = f_month_len(w_ay_up, r_artik);
  assign w_len_dn  = f_month_len(w_ay_dn, r_artik);

  always_comb begin
    w_gun_nxt   = r_gun;
    w_ay_nxt    = r_ay;
    w_tasma_nxt = 1'b0;
    w_act       = 1'b0;
    // An out-of-range day (e.g. Feb 29 after the leap flag drops) is pulled
    // back to the month end before anything else is allowed to move.
    if (r_gun > w_len) begin
      w_gun_nxt = w_len;
    end else if (!stop && gun_tick) begin
      if (r_gun < w_len) begin
        w_gun_nxt = r_gun + 5'd1;
      end else begin
        w_gun_nxt = 5'd1;
        if (r_ay < 4'd12) begin
          w_ay_nxt = r_ay + 4'd1;
        end else begin
          w_ay_nxt    = 4'd1;
          w_tasma_nxt = 1'b1;
        end
      end
    end else if (stop && r_arm && w_any_btn) begin
      w_act = 1'b1;
      if (gun_arttir) begin
        w_gun_nxt = (r_gun >= w_len) ? 5'd1 : r_gun + 5'd1;
      end else if (gun_azalt) begin
        w_gun_nxt = (r_gun <= 5'd1) ? w_len : r_gun - 5'd1;
      end else if (ay_arttir) begin
        w_ay_nxt  = w_ay_up;
        w_gun_nxt = (r_gun > w_len_up) ? w_len_up : r_gun;
      end else begin
        w_ay_nxt  = w_ay_dn;
        w_gun_nxt = (r_gun > w_len_dn) ? w_len_dn : r_gun;
      end
    end
  end

  // One action per press: the arm flag only comes back once every button is released.
  assign w_arm_nxt = !w_any_btn ? 1'b1 : (w_act ? 1'b0 : r_arm);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_gun   <= 5'd1;
      r_ay    <= 4'd1;
      r_tasma <= 1'b0;
      r_arm   <= 1'b1;
    end else begin
      r_gun   <= w_gun_nxt;
      r_ay    <= w_ay_nxt;
      r_tasma <= w_tasma_nxt;
      r_arm   <= w_arm_nxt;
    end
  end

  // Leap flag tracks yil every edge, so it is valid one edge after reset too.
  always_ff @(posedge clk) begin
    r_artik <= w_leap;
  end

  assign gun       = r_gun;
  assign ay        = r_ay;
  assign yil_tasma = r_tasma;
  assign artik_yil = r_artik;

endmodule
